// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_param
// Description : Parameterised UART transmitter (start, 5..9 data bits LSB
//               first, optional even/odd parity, 1 or 2 stop bits). Define
//               UART_TX_PAUSE_EN to append one idle-high PAUSE bit period
//               after the stop bits, before tx_done and IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_param #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int BAUD_DIV  = 10417
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 TxD
);

  localparam int c_BAUD_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  // DATA_BITS >= 5, so this width also covers the stop-bit count.
  localparam int c_BIT_W  = $clog2(DATA_BITS);

  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(BAUD_DIV - 1);
  localparam logic [c_BIT_W-1:0]  c_DATA_LAST = c_BIT_W'(DATA_BITS - 1);
  localparam logic [c_BIT_W-1:0]  c_STOP_LAST = c_BIT_W'(STOP_BITS - 1);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_START  = 3'd1;
  localparam logic [2:0] c_ST_DATA   = 3'd2;
  localparam logic [2:0] c_ST_PARITY = 3'd3;
  localparam logic [2:0] c_ST_STOP   = 3'd4;
`ifdef UART_TX_PAUSE_EN
  localparam logic [2:0] c_ST_PAUSE     = 3'd5;
  localparam logic [2:0] c_ST_STOP_EXIT = c_ST_PAUSE;
`else
  localparam logic [2:0] c_ST_STOP_EXIT = c_ST_IDLE;
`endif

  logic [2:0]           r_state;
  logic [2:0]           w_state_next;
  logic [c_BAUD_W-1:0]  r_baud_cnt;
  logic [c_BAUD_W-1:0]  w_baud_next;
  logic [c_BIT_W-1:0]   r_bit_cnt;
  logic [c_BIT_W-1:0]   w_bit_next;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_txd;
  logic                 r_done;
  logic                 w_load;
  logic                 w_tick;
  logic                 w_parity_bit;
  logic                 w_txd_next;
  logic                 w_done_next;

  assign w_tick = (r_baud_cnt == c_BAUD_LAST);

  generate
    if (PARITY == 1) begin : g_par_even
      assign w_parity_bit = ^r_data;
    end else if (PARITY == 2) begin : g_par_odd
      assign w_parity_bit = ~^r_data;
    end else begin : g_par_none
      assign w_parity_bit = 1'b0;
    end
  endgenerate

  // State register plus the registered line/pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_ST_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_data     <= '0;
      r_txd      <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_baud_cnt <= w_baud_next;
      r_bit_cnt  <= w_bit_next;
      if (w_load) begin
        r_data <= tx_data;
      end
      r_txd      <= w_txd_next;
      r_done     <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud_cnt + 1'b1;
    w_bit_next   = r_bit_cnt;
    w_load       = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        w_baud_next = '0;
        w_bit_next  = '0;
        if (tx_valid) begin
          w_state_next = c_ST_START;
          w_load       = 1'b1;
        end
      end
      c_ST_START: begin
        if (w_tick) begin
          w_baud_next  = '0;
          w_state_next = c_ST_DATA;
        end
      end
      c_ST_DATA: begin
        if (w_tick) begin
          w_baud_next = '0;
          if (r_bit_cnt == c_DATA_LAST) begin
            w_bit_next   = '0;
            w_state_next = (PARITY != 0) ? c_ST_PARITY : c_ST_STOP;
          end else begin
            w_bit_next = r_bit_cnt + 1'b1;
          end
        end
      end
      c_ST_PARITY: begin
        if (w_tick) begin
          w_baud_next  = '0;
          w_state_next = c_ST_STOP;
        end
      end
      c_ST_STOP: begin
        if (w_tick) begin
          w_baud_next = '0;
          if (r_bit_cnt == c_STOP_LAST) begin
            w_bit_next   = '0;
            w_state_next = c_ST_STOP_EXIT;
          end else begin
            w_bit_next = r_bit_cnt + 1'b1;
          end
        end
      end
`ifdef UART_TX_PAUSE_EN
      c_ST_PAUSE: begin
        if (w_tick) begin
          w_baud_next  = '0;
          w_state_next = c_ST_IDLE;
        end
      end
`endif
      default: begin
        w_state_next = c_ST_IDLE;
        w_baud_next  = '0;
        w_bit_next   = '0;
      end
    endcase
  end

  // Line level is decoded from the upcoming state so TxD can be a flop.
  always_comb begin
    w_txd_next = 1'b1;
    case (w_state_next)
      c_ST_START:  w_txd_next = 1'b0;
      c_ST_DATA:   w_txd_next = r_data[w_bit_next];
      c_ST_PARITY: w_txd_next = w_parity_bit;
      default:     w_txd_next = 1'b1;
    endcase
    w_done_next = (w_state_next == c_ST_IDLE) && (r_state != c_ST_IDLE);
  end

  assign tx_ready = (r_state == c_ST_IDLE);
  assign tx_busy  = (r_state == c_ST_START) || (r_state == c_ST_DATA) ||
                    (r_state == c_ST_PARITY) || (r_state == c_ST_STOP);
  assign tx_done  = r_done;
  assign TxD      = r_txd;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_param
// Description : Self-checking bench for uart_tx_param: four parameter sets,
//               directed and random frames against a bit-list frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_param;

  localparam int BD = 4;
`ifdef UART_TX_PAUSE_EN
  localparam int PAUSE_BITS = 1;
`else
  localparam int PAUSE_BITS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] valid;
  logic [3:0] ready;
  logic [3:0] busy;
  logic [3:0] done;
  logic [3:0] txd;
  logic [7:0] tdata [4];

  int checks   = 0;
  int failures = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  uart_tx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .BAUD_DIV(BD)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .tx_valid(valid[0]), .tx_data(tdata[0]),
    .tx_ready(ready[0]), .tx_busy(busy[0]), .tx_done(done[0]), .TxD(txd[0]));
  uart_tx_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .BAUD_DIV(BD)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .tx_valid(valid[1]), .tx_data(tdata[1]),
    .tx_ready(ready[1]), .tx_busy(busy[1]), .tx_done(done[1]), .TxD(txd[1]));
  uart_tx_param #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .BAUD_DIV(BD)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .tx_valid(valid[2]), .tx_data(tdata[2][6:0]),
    .tx_ready(ready[2]), .tx_busy(busy[2]), .tx_done(done[2]), .TxD(txd[2]));
  uart_tx_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .BAUD_DIV(BD)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .tx_valid(valid[3]), .tx_data(tdata[3]),
    .tx_ready(ready[3]), .tx_busy(busy[3]), .tx_done(done[3]), .TxD(txd[3]));

  function automatic int db(input int idx);
    return (idx == 2) ? 7 : 8;
  endfunction
  function automatic int par(input int idx);
    return (idx == 1) ? 1 : ((idx == 3) ? 2 : 0);
  endfunction
  function automatic int sb(input int idx);
    return (idx == 2) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input int idx, input int k,
                     input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut=%0d step=%0d observed=%b expected=%b", tag, idx, k, obs, exp);
    end
  endtask

  // Expected line level per bit period: start, data LSB first, parity, stops.
  task automatic build_frame(input int idx, input logic [7:0] w);
    int ones;
    ones = 0;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int j = 0; j < db(idx); j++) begin
      exp_q.push_back(w[j]);
      ones += int'(w[j]);
    end
    if (par(idx) == 1) exp_q.push_back(bit'(ones % 2));
    else if (par(idx) == 2) exp_q.push_back(bit'((ones + 1) % 2));
    for (int j = 0; j < sb(idx); j++) exp_q.push_back(1'b1);
  endtask

  // Called at a negedge with the DUT idle; accept happens on the next posedge.
  task automatic run_frame(input int idx, input logic [7:0] w,
                           input bit hold, input logic [7:0] nxt);
    int nclk;
    chk("ready_before_accept", idx, -1, ready[idx], 1'b1);
    valid[idx] = 1'b1;
    tdata[idx] = w;
    @(posedge clk);
    build_frame(idx, w);
    nclk = exp_q.size() * BD;
    for (int k = 0; k < nclk; k++) begin
      @(negedge clk);
      chk("txd", idx, k, txd[idx], exp_q[k / BD]);
      chk("busy", idx, k, busy[idx], 1'b1);
      chk("ready_mid", idx, k, ready[idx], 1'b0);
      chk("done_mid", idx, k, done[idx], 1'b0);
      if (hold) begin
        valid[idx] = 1'b1;
        tdata[idx] = nxt;
      end else begin
        valid[idx] = 1'($urandom_range(0, 1));
        tdata[idx] = 8'($urandom);
      end
    end
    for (int k = 0; k < PAUSE_BITS * BD; k++) begin
      @(negedge clk);
      chk("pause_txd", idx, nclk + k, txd[idx], 1'b1);
      chk("pause_busy", idx, nclk + k, busy[idx], 1'b0);
      chk("pause_ready", idx, nclk + k, ready[idx], 1'b0);
      chk("pause_done", idx, nclk + k, done[idx], 1'b0);
      if (!hold) valid[idx] = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    chk("done_pulse", idx, nclk, done[idx], 1'b1);
    chk("ready_end", idx, nclk, ready[idx], 1'b1);
    chk("busy_end", idx, nclk, busy[idx], 1'b0);
    chk("txd_end", idx, nclk, txd[idx], 1'b1);
    if (!hold) begin
      valid[idx] = 1'b0;
      @(negedge clk);
      chk("done_clear", idx, nclk + 1, done[idx], 1'b0);
      chk("idle_txd", idx, nclk + 1, txd[idx], 1'b1);
      chk("idle_busy", idx, nclk + 1, busy[idx], 1'b0);
    end
  endtask

  initial begin
    logic [7:0] w;
    logic [7:0] w2;
    int         idx;

    rst_n = 1'b0;
    valid = '0;
    for (int i = 0; i < 4; i++) tdata[i] = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("rst_txd", i, 0, txd[i], 1'b1);
      chk("rst_ready", i, 0, ready[i], 1'b1);
      chk("rst_busy", i, 0, busy[i], 1'b0);
      chk("rst_done", i, 0, done[i], 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    run_frame(0, 8'h55, 1'b0, 8'h00);
    run_frame(1, 8'h07, 1'b0, 8'h00);
    run_frame(3, 8'h07, 1'b0, 8'h00);
    run_frame(2, 8'h7F, 1'b0, 8'h00);
    run_frame(2, 8'h80, 1'b0, 8'h00);
    run_frame(0, 8'hA5, 1'b1, 8'h3C);
    run_frame(0, 8'h3C, 1'b0, 8'h00);

    // Abandon a frame in data bit 3, then send a clean word.
    valid[0] = 1'b1;
    tdata[0] = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (17) @(negedge clk);
    chk("pre_rst_busy", 0, 17, busy[0], 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_txd", 0, 0, txd[0], 1'b1);
    chk("async_rst_busy", 0, 0, busy[0], 1'b0);
    chk("async_rst_ready", 0, 0, ready[0], 1'b1);
    chk("async_rst_done", 0, 0, done[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_txd", 0, 0, txd[0], 1'b1);
    run_frame(0, 8'h81, 1'b0, 8'h00);

    for (int r = 0; r < 24; r++) begin
      idx = $urandom_range(0, 3);
      w   = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        w2 = 8'($urandom);
        run_frame(idx, w, 1'b1, w2);
        run_frame(idx, w2, 1'b0, 8'h00);
      end else begin
        run_frame(idx, w, 1'b0, 8'h00);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
